// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue and the decode-side
// instruction register.
package fetch_pkg;

    typedef enum logic {FQ_RUN, FQ_SEEK} fq_state_t;

    // Word that decodes as NOP; also the instruction register's reset value.
    localparam logic [31:0] NOP_WORD = 32'h0000_0020;

endpackage

// File: rtl/fq_storage.sv
// DEPTH-entry register array for the fetch queue: one write port, combinational
// read at the read address, and a synchronous clear.
module fq_storage #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; the owner's occupancy count decides which
    // entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction buffer between instruction memory and decode: a DEPTH-entry queue of
// {pc, word} with flush/redirect handling and a saturating count of dropped words.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int              BITS     = 32,
    parameter int              PC_BITS  = 32,
    parameter int              DEPTH    = 4,
    parameter logic [BITS-1:0] NOP_WORD = BITS'(fetch_pkg::NOP_WORD),
    parameter int              CNT_BITS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_valid,
    input  logic [BITS-1:0]            mem_data,
    input  logic [PC_BITS-1:0]         mem_pc,
    output logic                       mem_ready,
    input  logic                       flush,
    input  logic [PC_BITS-1:0]         redirect_pc,
    input  logic                       dec_ready,
    output logic [BITS-1:0]            instr,
    output logic [PC_BITS-1:0]         instr_pc,
    output logic                       instr_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_BITS-1:0]        drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = BITS + PC_BITS;

    fq_state_t          state, state_n;
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      count_q;
    logic [PC_BITS-1:0] target;
    logic [CNT_BITS-1:0] drop_q;
    logic [EW-1:0]      head;

    logic accept, release_req, push, pop, drop;

    assign mem_ready   = (count_q != CW'(DEPTH));
    assign instr_valid = (count_q != '0);
    assign accept      = mem_valid && mem_ready;
    assign release_req = instr_valid && dec_ready;

    // NOTE: every signal written here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        push    = 1'b0;
        pop     = 1'b0;
        drop    = 1'b0;
        if (flush) begin
            state_n = FQ_SEEK;
            drop    = accept;
        end else begin
            unique case (state)
                FQ_RUN: begin
                    push = accept;
                    pop  = release_req;
                end
                FQ_SEEK: begin
                    if (accept && mem_pc == target) begin
                        push    = 1'b1;
                        state_n = FQ_RUN;
                    end else begin
                        drop = accept;
                    end
                end
                default: state_n = FQ_RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FQ_RUN;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            target  <= '0;
            drop_q  <= '0;
        end else begin
            state <= state_n;
            if (flush) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count_q <= '0;
                target  <= redirect_pc;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                unique case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
            if (drop && drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end

    fq_storage #(
        .W     (EW),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_storage (
        .clk   (clk),
        .clear (flush),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({mem_pc, mem_data}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Empty queue presents a bubble that decodes as NOP.
    assign instr    = instr_valid ? head[BITS-1:0]     : NOP_WORD;
    assign instr_pc = instr_valid ? head[EW-1:BITS]    : '0;
    assign count    = count_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: stimulus pushes accepted words into a
// reference queue, a negedge monitor compares the DUT head and status against it.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CB    = 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0020;

    logic          clk, rst;
    logic          mem_valid, mem_ready, flush, dec_ready, instr_valid;
    logic [31:0]   mem_data, mem_pc, redirect_pc, instr, instr_pc;
    logic [CW-1:0] count;
    logic [CB-1:0] drop_cnt;

    instr_fetch_queue #(
        .BITS     (32),
        .PC_BITS  (32),
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP),
        .CNT_BITS (CB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_valid   (mem_valid),
        .mem_data    (mem_data),
        .mem_pc      (mem_pc),
        .mem_ready   (mem_ready),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .dec_ready   (dec_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .count       (count),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    // Reference model: queue contents, seek flag, target and drop total.
    ent_t        mq[$];
    bit          seek;
    logic [31:0] tgt;
    int          drops;
    int          total, bad;
    bit          done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        seek  = 1'b0;
        tgt   = '0;
        drops = 0;
    endfunction

    function automatic void drop_one();
        if (drops < (1 << CB) - 1) drops++;
    endfunction

    // One cycle: drive inputs, then apply the architectural rules at the edge.
    task automatic step(input bit v, input logic [31:0] pc, input bit fl,
                        input logic [31:0] rpc, input bit dr, input bit r);
        bit          rdy;
        logic [31:0] data;
        data        = $urandom;
        mem_valid   = v;
        mem_pc      = pc;
        mem_data    = data;
        flush       = fl;
        redirect_pc = rpc;
        dec_ready   = dr;
        rst         = r;
        if (r) model_reset();
        rdy = (mq.size() < DEPTH);
        @(posedge clk);
        if (!r) begin
            if (fl) begin
                mq.delete();
                seek = 1'b1;
                tgt  = rpc;
                if (v && rdy) drop_one();
            end else if (v && rdy) begin
                if (!seek || pc == tgt) begin
                    mq.push_back('{pc: pc, word: data});
                    seek = 1'b0;
                end else begin
                    drop_one();
                end
            end
        end
        #1;
    endtask

    // Monitor: compares status every cycle and retires the head on a release.
    always @(negedge clk) begin
        int sz;
        if (!done) begin
            sz = mq.size();
            check("count",       64'(count),       64'(sz));
            check("mem_ready",   64'(mem_ready),   64'(sz != DEPTH));
            check("instr_valid", 64'(instr_valid), 64'(sz != 0));
            check("drop_cnt",    64'(drop_cnt),    64'(drops));
            if (sz != 0) begin
                check("instr",    64'(instr),    64'(mq[0].word));
                check("instr_pc", 64'(instr_pc), 64'(mq[0].pc));
                if (dec_ready && !flush && !rst) void'(mq.pop_front());
            end else begin
                check("nop_instr", 64'(instr),    64'(NOP));
                check("nop_pc",    64'(instr_pc), 64'd0);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        done  = 1'b0;
        model_reset();
        rst = 1'b1; mem_valid = 1'b0; mem_pc = '0; mem_data = '0;
        flush = 1'b0; redirect_pc = '0; dec_ready = 1'b0;

        // Reset, then fill to full with decode stalled, try one extra push.
        repeat (2) step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 32'(i * 4), 0, 0, 0, 0);
        step(1, 32'h10, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);

        // Wrap-around stream with decode toggling.
        for (int i = 0; i < 10; i++) step(1, 32'h100 + 32'(i * 4), 0, 0, i % 2 == 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0);

        // Simultaneous push and pop at count 2.
        step(1, 32'h200, 0, 0, 0, 0);
        step(1, 32'h204, 0, 0, 0, 0);
        step(1, 32'h208, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // Flush while pushing, then seek through two wrong PCs to the target.
        step(1, 32'h10, 1, 32'h40, 1, 0);
        step(1, 32'h14, 0, 0, 0, 0);
        step(1, 32'h18, 0, 0, 0, 0);
        step(1, 32'h40, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);

        // Drop counter saturation.
        step(0, 0, 1, 32'h80, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 32'h300 + 32'(i * 4), 0, 0, 0, 0);

        // Reset mid-stream with three entries queued.
        step(1, 32'h80, 0, 0, 0, 0);
        step(1, 32'h84, 0, 0, 0, 0);
        step(1, 32'h88, 0, 0, 0, 0);
        step(1, 32'h8C, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Randomised traffic with occasional flushes and resets.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0,
                 32'h40 + 32'($urandom_range(0, 3) * 4),
                 $urandom_range(0, 19) == 0,
                 32'h40 + 32'($urandom_range(0, 3) * 4),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 199) == 0);
        end
        step(0, 0, 0, 0, 1, 0);

        @(negedge clk);
        #1;
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Parametrised instruction buffer between instruction memory and the instruction decode stage. It replaces the single-word instruction register load path with a DEPTH-entry queue that carries each word's PC. Words are accepted and released through valid/ready handshakes. A flush empties the queue and discards fetched words until the redirect target arrives; an empty queue presents the NOP word to decode.

## Interface
Parameters:
- BITS, 32, instruction word width
- PC_BITS, 32, PC tag width
- DEPTH, 4, queue entries; power of two, ≥2
- NOP_WORD, 32'h0000_0020, word presented when empty
- CNT_BITS, 16, width of saturating drop counter

Ports (clock and reset first):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mem_valid  in  1  instruction memory presents a word
- mem_data  in  BITS  instruction word
- mem_pc  in  PC_BITS  address of mem_data
- mem_ready  out  1  queue accepts a word this cycle
- flush  in  1  taken branch/jump/jreg/exception; discard everything
- redirect_pc  in  PC_BITS  target PC, sampled when flush=1
- dec_ready  in  1  decode consumes head this cycle
- instr  out  BITS  head word, NOP_WORD when empty
- instr_pc  out  PC_BITS  head PC, 0 when empty
- instr_valid  out  1  head holds a real instruction
- count  out  $clog2(DEPTH+1)  occupied entries
- drop_cnt  out  CNT_BITS  words discarded since reset; saturates at all-ones

## Operation
- **Storage:** circular array with rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH, and a separate occupancy count.
- **Accept:** a word is accepted on mem_valid && mem_ready.
- **mem_ready:** equals (count != DEPTH). It depends only on registered state and never on flush. There is no push-when-full bypass.
- **Release:** the head is released on instr_valid && dec_ready.
- **instr_valid:** equals (count != 0) and comes from registered state.
- **State RUN:** an accepted word is written at wr_ptr. Push and pop in the same cycle leave count unchanged.
- **State SEEK:** the queue is empty and target holds redirect_pc.
  - If an accepted word has mem_pc == target, it is pushed and the state goes to RUN.
  - Otherwise the word is dropped and drop_cnt increments.
- **flush=1 in any state (highest priority):**
  - count, rd_ptr and wr_ptr clear.
  - target <= redirect_pc and the state goes to SEEK.
  - Any word accepted in the same cycle is dropped and counted.
  - Any pop requested in the same cycle is ignored.
- **flush while already in SEEK:** target is reloaded and the state stays SEEK.
- **drop_cnt:** increments by at most 1 per cycle and holds at 2^CNT_BITS-1.
- **Empty output:** when count == 0, instr=NOP_WORD and instr_pc=0. Decode therefore sees a bubble that decodes as NOP.

## Timing
- **Reset (rst=1, asynchronous):**
  - state=RUN, count=0, pointers=0, target=0, drop_cnt=0.
  - Outputs during reset: instr=NOP_WORD, instr_pc=0, instr_valid=0, mem_ready=1.
- **Reset mid-operation:** all queue contents are lost immediately. Recovery begins on the first clock edge after rst falls.
- **Latency:** a word accepted at edge N appears on instr/instr_valid after edge N when the queue was empty; otherwise it appears after all older entries are released. There is no combinational path from mem_data to instr.
- **Throughput:** one accept and one release per cycle, sustained when 0 < count < DEPTH.
- **Full (count == DEPTH):** mem_ready=0. A pop in that cycle frees a slot; mem_ready rises the next cycle.
- **Empty with dec_ready=1:** no pop occurs and count stays 0.
- **Head stability:** instr and instr_pc are stable for the whole cycle and change only on a clock edge.

## Structure
- Shared package `fetch_pkg`:
  - typedef enum logic {FQ_RUN, FQ_SEEK} fq_state_t
  - localparam NOP_WORD, used both for the empty-queue word and the instruction-register reset value.
- Sub-module `fq_storage`: DEPTH×(BITS+PC_BITS) register array with write port, combinational read at rd_ptr, and clear.
- The top level holds the pointers, count, SEEK state machine and drop counter.

## Test plan
- **Reset:** assert rst mid-stream with count=3 -> instr=32'h0000_0020, instr_valid=0, count=0, mem_ready=1 during reset.
- **Fill to full:** push 4 words with pc 0x00..0x0C and dec_ready=0 -> count=4 and mem_ready=0. Then dec_ready=1 -> words released in order, instr_pc 0x00, 0x04, 0x08, 0x0C.
- **Wrap-around:** stream 10 words with dec_ready toggling 1/0 -> output order matches input and pointers wrap without loss.
- **Simultaneous push/pop at count=2:** count stays 2 and the head advances by one.
- **Flush/SEEK:** flush with redirect_pc=0x40 while pushing pc 0x10 -> count=0. Then feed pc 0x14, 0x18, 0x40 -> first two dropped (drop_cnt +2), 0x40 becomes head with instr_valid=1.
- **Saturation:** with CNT_BITS=2, drop 5 words in SEEK -> drop_cnt holds at 3.
